// File: rtl/cache_pkg.sv
// Shared definitions for the associative write-back cache.
//   state_t       : cache controller states
//   MEM_RD/MEM_WR : encoding of req_rw and mem_rw (0 = read, 1 = write)
//   clog2()       : ceiling log2, used to size way indices and LRU ages
package cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WB,
        ST_FILL,
        ST_RESP,
        ST_FL_SCAN,
        ST_FL_WB
    } state_t;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cache_lru_ages.sv
// LRU age bookkeeping and victim selection for the associative cache.
// Ages form a permutation of 0..N_WAYS-1 (0 = most recently used).
// Ports:
//   clk, clr   : clock and synchronous active-high reset (age[w] = w)
//   valid      : per-way valid bits from the cache
//   touch      : access or install to way touch_way this cycle
//   touch_way  : way being accessed or installed
//   victim     : lowest-index invalid way, else the way with the maximum age
module cache_lru_ages
    import cache_pkg::*;
#(
    parameter  int N_WAYS = 4,
    localparam int WAY_W  = clog2(N_WAYS)
)(
    input  logic              clk,
    input  logic              clr,
    input  logic [N_WAYS-1:0] valid,
    input  logic              touch,
    input  logic [WAY_W-1:0]  touch_way,
    output logic [WAY_W-1:0]  victim
);

    logic [WAY_W-1:0] age_q [N_WAYS];
    logic [WAY_W-1:0] touch_age;

    assign touch_age = age_q[touch_way];

    // Younger valid ways age by one; the touched way becomes youngest.
    // Invalid ways keep their ages so the permutation stays intact.
    // NOTE: sequential state uses <= so every way compares against the
    // pre-update ages; blocking writes would ripple through the loop.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int w = 0; w < N_WAYS; w++) age_q[w] <= WAY_W'(w);
        end else if (touch) begin
            for (int w = 0; w < N_WAYS; w++) begin
                if (WAY_W'(w) == touch_way)
                    age_q[w] <= '0;
                else if (valid[w] && (age_q[w] < touch_age))
                    age_q[w] <= age_q[w] + WAY_W'(1);
            end
        end
    end

    // NOTE: victim gets a default before the loops so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        victim = '0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (age_q[w] == WAY_W'(N_WAYS - 1)) victim = WAY_W'(w);
        end
        // Second pass overrides: the lowest invalid way wins over the oldest.
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            if (!valid[w]) victim = WAY_W'(w);
        end
    end

endmodule

// File: rtl/assoc_cache_wb.sv
// Fully associative, write-back, write-allocate cache with LRU replacement.
// Optional macro CACHE_STATS_EN adds saturating hit/miss/write-back counters.
// Ports:
//   clk, clr                      : clock, synchronous active-high reset
//   req_valid/req_ready           : request handshake (rw, addr, wdata)
//   resp_valid/resp_rdata/resp_hit: one-cycle completion pulse
//   flush_req/flush_done          : write back every dirty line
//   mem_req/mem_rw/mem_addr/
//   mem_wdata/mem_ack/mem_rdata   : backing RAM req/ack interface
//   hit_count/miss_count/wb_count : statistics (CACHE_STATS_EN only)
module assoc_cache_wb
    import cache_pkg::*;
#(
    parameter int A_WIDTH = 8,
    parameter int D_WIDTH = 8,
    parameter int N_WAYS  = 4
)(
    input  logic               clk,
    input  logic               clr,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_rw,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_wdata,
    output logic               resp_valid,
    output logic [D_WIDTH-1:0] resp_rdata,
    output logic               resp_hit,
    input  logic               flush_req,
    output logic               flush_done,
    output logic               mem_req,
    output logic               mem_rw,
    output logic [A_WIDTH-1:0] mem_addr,
    output logic [D_WIDTH-1:0] mem_wdata,
    input  logic               mem_ack,
`ifdef CACHE_STATS_EN
    input  logic [D_WIDTH-1:0] mem_rdata,
    output logic [15:0]        hit_count,
    output logic [15:0]        miss_count,
    output logic [15:0]        wb_count
`else
    input  logic [D_WIDTH-1:0] mem_rdata
`endif
);

    localparam int WAY_W = clog2(N_WAYS);
    localparam int IDX_W = WAY_W + 1;   // flush index also encodes "past last way"

    state_t             state_q, state_d;
    logic               rw_q, hit_q;
    logic [A_WIDTH-1:0] addr_q;
    logic [D_WIDTH-1:0] wdata_q;
    logic [WAY_W-1:0]   victim_q, victim_c, hit_way, way_sel, flush_way;
    logic [IDX_W-1:0]   flush_idx_q;
    logic               flush_end;
    logic [N_WAYS-1:0]  valid_q, dirty_q;
    logic [A_WIDTH-1:0] tag_q  [N_WAYS];
    logic [D_WIDTH-1:0] data_q [N_WAYS];
    logic               hit, victim_dirty, fl_dirty;
    logic               touch, install_wr, install_rd, wb_ack;

    // Tag match against valid ways; at most one way can match.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = 0; w < N_WAYS; w++) begin
            if (valid_q[w] && (tag_q[w] == addr_q)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // In LOOKUP the target way is combinational; later states use the latched victim.
    assign way_sel      = (state_q == ST_LOOKUP) ? (hit ? hit_way : victim_c) : victim_q;
    assign victim_dirty = valid_q[victim_c] && dirty_q[victim_c];
    assign flush_way    = flush_idx_q[WAY_W-1:0];
    assign flush_end    = (flush_idx_q == IDX_W'(N_WAYS));
    assign fl_dirty     = valid_q[flush_way] && dirty_q[flush_way];

    assign install_wr = ((state_q == ST_LOOKUP) && !hit && (rw_q == MEM_WR) && !victim_dirty)
                     || ((state_q == ST_WB) && mem_ack && (rw_q == MEM_WR));
    assign install_rd = (state_q == ST_FILL) && mem_ack;
    assign touch      = ((state_q == ST_LOOKUP) && hit) || install_wr || install_rd;
    assign wb_ack     = ((state_q == ST_WB) || (state_q == ST_FL_WB)) && mem_ack;

    cache_lru_ages #(.N_WAYS(N_WAYS)) u_lru (
        .clk       (clk),
        .clr       (clr),
        .valid     (valid_q),
        .touch     (touch),
        .touch_way (way_sel),
        .victim    (victim_c)
    );

    always_ff @(posedge clk) begin
        if (clr) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:
                if (flush_req)      state_d = ST_FL_SCAN;
                else if (req_valid) state_d = ST_LOOKUP;
            ST_LOOKUP:
                if (hit)                  state_d = ST_RESP;
                else if (victim_dirty)    state_d = ST_WB;
                else if (rw_q == MEM_RD)  state_d = ST_FILL;
                else                      state_d = ST_RESP;
            ST_WB:
                if (mem_ack) state_d = (rw_q == MEM_RD) ? ST_FILL : ST_RESP;
            ST_FILL:
                if (mem_ack) state_d = ST_RESP;
            ST_RESP:
                state_d = ST_IDLE;
            ST_FL_SCAN:
                if (flush_end)     state_d = ST_IDLE;
                else if (fl_dirty) state_d = ST_FL_WB;
            ST_FL_WB:
                if (mem_ack) state_d = ST_FL_SCAN;
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_hit   = 1'b0;
        flush_done = 1'b0;
        mem_req    = 1'b0;
        mem_rw     = MEM_RD;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state_q)
            ST_IDLE:    req_ready = !flush_req;
            ST_WB: begin
                mem_req   = 1'b1;
                mem_rw    = MEM_WR;
                mem_addr  = tag_q[victim_q];
                mem_wdata = data_q[victim_q];
            end
            ST_FILL: begin
                mem_req  = 1'b1;
                mem_addr = addr_q;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_hit   = hit_q;
            end
            ST_FL_SCAN: flush_done = flush_end;
            ST_FL_WB: begin
                mem_req   = 1'b1;
                mem_rw    = MEM_WR;
                mem_addr  = tag_q[flush_way];
                mem_wdata = data_q[flush_way];
            end
            default: ;
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q     <= '0;
            dirty_q     <= '0;
            rw_q        <= MEM_RD;
            hit_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            victim_q    <= '0;
            flush_idx_q <= '0;
            resp_rdata  <= '0;
        end else begin
            if ((state_q == ST_IDLE) && req_valid && req_ready) begin
                rw_q    <= req_rw;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if ((state_q == ST_IDLE) && flush_req)
                flush_idx_q <= '0;
            if (state_q == ST_LOOKUP) begin
                hit_q    <= hit;
                victim_q <= victim_c;
                if (hit && (rw_q == MEM_RD)) resp_rdata <= data_q[hit_way];
                if (hit && (rw_q == MEM_WR)) dirty_q[hit_way] <= 1'b1;
            end
            if (install_wr) begin
                valid_q[way_sel] <= 1'b1;
                dirty_q[way_sel] <= 1'b1;
            end
            if (install_rd) begin
                valid_q[way_sel] <= 1'b1;
                dirty_q[way_sel] <= 1'b0;
                resp_rdata       <= mem_rdata;
            end
            if ((state_q == ST_FL_SCAN) && !flush_end && !fl_dirty)
                flush_idx_q <= flush_idx_q + IDX_W'(1);
            if ((state_q == ST_FL_WB) && mem_ack) begin
                dirty_q[flush_way] <= 1'b0;
                flush_idx_q        <= flush_idx_q + IDX_W'(1);
            end
        end
    end

    // NOTE: tag and data storage is not reset; valid bits gate every use,
    // so clearing the arrays would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (!clr) begin
            if ((state_q == ST_LOOKUP) && hit && (rw_q == MEM_WR))
                data_q[hit_way] <= wdata_q;
            if (install_wr) begin
                tag_q[way_sel]  <= addr_q;
                data_q[way_sel] <= wdata_q;
            end
            if (install_rd) begin
                tag_q[way_sel]  <= addr_q;
                data_q[way_sel] <= mem_rdata;
            end
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (clr) begin
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            if ((state_q == ST_LOOKUP) && hit && (hit_count != 16'hFFFF))
                hit_count <= hit_count + 16'd1;
            if ((state_q == ST_LOOKUP) && !hit && (miss_count != 16'hFFFF))
                miss_count <= miss_count + 16'd1;
            if (wb_ack && (wb_count != 16'hFFFF))
                wb_count <= wb_count + 16'd1;
        end
    end
`else
    logic unused_wb_ack;
    assign unused_wb_ack = wb_ack;
`endif

endmodule

// File: tb/tb_assoc_cache_wb.sv
// Self-checking bench for assoc_cache_wb: response and memory-transaction
// scoreboards plus per-scenario timing and handshake checks.
module tb_assoc_cache_wb;

    localparam int N_WAYS = 4;

    logic       clk = 1'b0;
    logic       clr, req_valid, req_rw, flush_req, mem_ack;
    logic [7:0] req_addr, req_wdata, mem_rdata;
    logic       req_ready, resp_valid, resp_hit, flush_done, mem_req, mem_rw;
    logic [7:0] resp_rdata, mem_addr, mem_wdata;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count, miss_count, wb_count;
`endif

    always #5 clk = ~clk;

    assoc_cache_wb #(.A_WIDTH(8), .D_WIDTH(8), .N_WAYS(N_WAYS)) dut (
        .clk        (clk),
        .clr        (clr),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rw     (req_rw),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_hit   (resp_hit),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .mem_req    (mem_req),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
`ifdef CACHE_STATS_EN
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .wb_count   (wb_count)
`else
        .mem_rdata  (mem_rdata)
`endif
    );

    typedef struct {
        logic       hit;
        logic [7:0] rdata;
    } resp_t;

    typedef struct {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
    } mem_t;

    resp_t      exp_resp_q[$];
    mem_t       exp_mem_q[$];
    resp_t      e_resp;
    mem_t       e_mem;
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] ram [256];
    logic [7:0] last_rd  = 8'h00;
    int         mem_lat  = 0;
    int         mem_wait = 0;
    bit         mem_stall = 1'b0;

    // Backing RAM model: acks after mem_lat observed request cycles and
    // checks each transaction against the expected-memory queue.
    always @(negedge clk) begin
        if (clr || mem_stall) begin
            mem_ack  = 1'b0;
            mem_wait = 0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (mem_req) begin
            if (mem_wait >= mem_lat) begin
                mem_wait = 0;
                checks++;
                if (exp_mem_q.size() == 0) begin
                    failures++;
                    $display("FAIL mem_unexpected: got rw=%0d addr=%h wdata=%h, required no access",
                             mem_rw, mem_addr, mem_wdata);
                end else begin
                    e_mem = exp_mem_q.pop_front();
                    if (mem_rw !== e_mem.rw || mem_addr !== e_mem.addr ||
                        (e_mem.rw && mem_wdata !== e_mem.wdata)) begin
                        failures++;
                        $display("FAIL mem_txn: got rw=%0d addr=%h wdata=%h, required rw=%0d addr=%h wdata=%h",
                                 mem_rw, mem_addr, mem_wdata, e_mem.rw, e_mem.addr, e_mem.wdata);
                    end
                end
                if (mem_rw) ram[mem_addr] = mem_wdata;
                else        mem_rdata     = ram[mem_addr];
                mem_ack = 1'b1;
            end else begin
                mem_wait++;
            end
        end
    end

    // Response scoreboard.
    always @(negedge clk) begin
        if (resp_valid) begin
            checks++;
            if (exp_resp_q.size() == 0) begin
                failures++;
                $display("FAIL resp_unexpected: got hit=%0d rdata=%h, required no response",
                         resp_hit, resp_rdata);
            end else begin
                e_resp = exp_resp_q.pop_front();
                if (resp_hit !== e_resp.hit || resp_rdata !== e_resp.rdata) begin
                    failures++;
                    $display("FAIL resp: got hit=%0d rdata=%h, required hit=%0d rdata=%h",
                             resp_hit, resp_rdata, e_resp.hit, e_resp.rdata);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk);
        clr = 1'b1; req_valid = 1'b0; flush_req = 1'b0;
        repeat (2) @(negedge clk);
        clr = 1'b0;
        last_rd = 8'h00;
    endtask

    // Issues one request, pushes its expected response, and reports the
    // cycles from accept to resp_valid and whether mem_req was seen.
    task automatic do_req(input logic rw, input logic [7:0] addr, input logic [7:0] wdata,
                          input logic exp_hit, input logic [7:0] exp_rdata,
                          output int lat, output bit saw_mem);
        int n;
        lat = 0;
        saw_mem = 1'b0;
        exp_resp_q.push_back('{exp_hit, rw ? last_rd : exp_rdata});
        if (!rw) last_rd = exp_rdata;
        @(negedge clk);
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wdata;
        #1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout: addr=%h req_ready=%0d, required 1", addr, req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        while (lat < 100) begin
            @(negedge clk); #1;
            lat++;
            if (mem_req) saw_mem = 1'b1;
            if (resp_valid) break;
        end
        if (!resp_valid) begin
            checks++; failures++;
            $display("FAIL resp_timeout: addr=%h resp_valid=%0d, required 1", addr, resp_valid);
        end
    endtask

    task automatic do_flush(output int cycles, output bit saw_mem);
        cycles = 0;
        saw_mem = 1'b0;
        @(negedge clk);
        flush_req = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready: req_ready=%0d, required 0", req_ready);
        end
        @(posedge clk); #1;
        flush_req = 1'b0;
        while (cycles < 200) begin
            @(negedge clk); #1;
            cycles++;
            if (mem_req) saw_mem = 1'b1;
            if (flush_done) break;
        end
        if (!flush_done) begin
            checks++; failures++;
            $display("FAIL flush_timeout: flush_done=%0d, required 1", flush_done);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_hit, flush_done, mem_req, mem_rw} !== 6'b100000 ||
            resp_rdata !== 8'h00 || mem_addr !== 8'h00 || mem_wdata !== 8'h00) begin
            failures++;
            $display("FAIL reset_outputs: rdy=%0d rv=%0d hit=%0d fd=%0d mreq=%0d mrw=%0d rdata=%h, required rdy=1 others 0",
                     req_ready, resp_valid, resp_hit, flush_done, mem_req, mem_rw, resp_rdata);
        end
    endtask

    task automatic test_read_miss_hit();
        int lat; bit saw;
        ram[8'h10] = 8'h5A;
        mem_lat = 3;
        exp_mem_q.push_back('{1'b0, 8'h10, 8'h00});
        do_req(1'b0, 8'h10, 8'h00, 1'b0, 8'h5A, lat, saw);
        mem_lat = 0;
        do_req(1'b0, 8'h10, 8'h00, 1'b1, 8'h5A, lat, saw);
        checks++;
        if (lat !== 2 || saw) begin
            failures++;
            $display("FAIL hit_latency: lat=%0d mem_req_seen=%0d, required lat=2 mem_req_seen=0", lat, saw);
        end
    endtask

    task automatic test_write_alloc();
        int lat; bit saw;
        do_req(1'b1, 8'h20, 8'hAA, 1'b0, 8'h00, lat, saw);
        checks++;
        if (saw) begin
            failures++;
            $display("FAIL write_alloc_mem: mem_req_seen=%0d, required 0", saw);
        end
        do_req(1'b0, 8'h20, 8'h00, 1'b1, 8'hAA, lat, saw);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL write_hit_latency: lat=%0d, required 2", lat);
        end
    endtask

    task automatic test_evict();
        int lat; bit saw;
        apply_reset();
        for (int i = 1; i <= 4; i++)
            do_req(1'b1, 8'(i), 8'(i * 17), 1'b0, 8'h00, lat, saw);
        do_req(1'b0, 8'h01, 8'h00, 1'b1, 8'h11, lat, saw);
        checks++;
        if (lat !== 2) begin
            failures++;
            $display("FAIL evict_hit_latency: lat=%0d, required 2", lat);
        end
        exp_mem_q.push_back('{1'b1, 8'h02, 8'h22});
        do_req(1'b1, 8'h05, 8'h55, 1'b0, 8'h00, lat, saw);
        exp_mem_q.push_back('{1'b1, 8'h03, 8'h33});
        exp_mem_q.push_back('{1'b0, 8'h02, 8'h00});
        do_req(1'b0, 8'h02, 8'h00, 1'b0, 8'h22, lat, saw);
    endtask

    task automatic test_flush();
        int cyc; bit saw;
        exp_mem_q.push_back('{1'b1, 8'h01, 8'h11});
        exp_mem_q.push_back('{1'b1, 8'h05, 8'h55});
        exp_mem_q.push_back('{1'b1, 8'h04, 8'h44});
        do_flush(cyc, saw);
        checks++;
        if (exp_mem_q.size() != 0) begin
            failures++;
            $display("FAIL flush_writes: pending=%0d, required 0", exp_mem_q.size());
        end
        do_flush(cyc, saw);
        checks++;
        if (cyc > N_WAYS + 2 || saw) begin
            failures++;
            $display("FAIL clean_flush: cycles=%0d mem_req_seen=%0d, required <=%0d and 0", cyc, saw, N_WAYS + 2);
        end
    endtask

    task automatic test_clr_mid_wb();
        int lat; bit saw; int n;
        apply_reset();
        for (int i = 1; i <= 4; i++)
            do_req(1'b1, 8'(i), 8'(i * 17), 1'b0, 8'h00, lat, saw);
        mem_stall = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 8'h05; req_wdata = 8'h66;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!mem_req && n < 20) begin
            @(negedge clk); #1; n++;
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (mem_req !== 1'b1 || mem_rw !== 1'b1 || mem_addr !== 8'h01 || mem_wdata !== 8'h11) begin
            failures++;
            $display("FAIL wb_hold: req=%0d rw=%0d addr=%h wdata=%h, required 1 1 01 11",
                     mem_req, mem_rw, mem_addr, mem_wdata);
        end
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (mem_req !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL clr_abort: mem_req=%0d req_ready=%0d, required 0 1", mem_req, req_ready);
        end
        clr = 1'b0;
        last_rd = 8'h00;
        mem_stall = 1'b0;
        ram[8'h05] = 8'h77;
        exp_mem_q.push_back('{1'b0, 8'h05, 8'h00});
        do_req(1'b0, 8'h05, 8'h00, 1'b0, 8'h77, lat, saw);
    endtask

    task automatic test_flush_vs_req();
        int lat; bit saw; int n; bit early;
        do_req(1'b1, 8'h30, 8'h3C, 1'b0, 8'h00, lat, saw);
        exp_mem_q.push_back('{1'b1, 8'h30, 8'h3C});
        exp_resp_q.push_back('{1'b1, 8'h77});
        @(negedge clk);
        flush_req = 1'b1; req_valid = 1'b1; req_rw = 1'b0; req_addr = 8'h05;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_priority: req_ready=%0d, required 0", req_ready);
        end
        @(posedge clk); #1;
        flush_req = 1'b0;
        n = 0; early = 1'b0;
        while (!flush_done && n < 100) begin
            @(negedge clk); #1; n++;
            if (req_ready) early = 1'b1;
        end
        checks++;
        if (!flush_done || early) begin
            failures++;
            $display("FAIL flush_then_req: flush_done=%0d ready_during_flush=%0d, required 1 0", flush_done, early);
        end
        @(negedge clk); #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_flush_ready: req_ready=%0d, required 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 50) begin
            @(negedge clk); #1; n++;
        end
        checks++;
        if (!resp_valid) begin
            failures++;
            $display("FAIL deferred_resp: resp_valid=%0d, required 1", resp_valid);
        end
    endtask

    initial begin
        clr = 1'b1; req_valid = 1'b0; req_rw = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
        flush_req = 1'b0; mem_ack = 1'b0; mem_rdata = 8'h00;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;

        test_reset();
        test_read_miss_hit();
        test_write_alloc();
        test_evict();
        test_flush();
        test_clr_mid_wb();
        test_flush_vs_req();

        repeat (3) @(negedge clk);
        checks++;
        if (exp_resp_q.size() != 0 || exp_mem_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: resp_pending=%0d mem_pending=%0d, required 0 0",
                     exp_resp_q.size(), exp_mem_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
